// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX arbiter and the future RX-side dispatcher.
//   UART_WORD_W       : payload width of one UART word (9 data bits)
//   UART_FRAME_CYCLES : txclk cycles per frame (start + 9 data + parity + stop)
//   arb_state_e       : arbiter FSM states
package uart_pkg;

    localparam int UART_WORD_W       = 9;
    localparam int UART_FRAME_CYCLES = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req   : request vector
//   last  : index granted most recently; the search starts just above it
//   valid : at least one request is set
//   idx   : first set request found from (last+1) mod N upward, with wrap
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest set bit is the
    // one left standing.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                valid = 1'b1;
                idx   = IW'((int'(last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NREQ requesters.
// The UART has no busy output, so frame length is timed with a local counter.
//   txclk, reset : bit clock, synchronous active-high reset
//   arb_en       : gates new grants only; a running frame always completes
//   req/req_data : per-requester request and 9-bit word (slot i at [9i+8:9i])
//   gnt          : one-hot single-cycle accept pulse
//   tx_enable/tx_load/tx_data : UART TX drive
//   busy         : high while sending or in the inter-frame gap
//   cur_id       : index of the requester last granted
//   frame_done   : single-cycle pulse at the end of each frame
//   frames_sent  : wrapping count of completed frames
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int FRAME_CYCLES = UART_FRAME_CYCLES,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                          txclk,
    input  logic                          reset,
    input  logic                          arb_en,
    input  logic [NREQ-1:0]               req,
    input  logic [UART_WORD_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]               gnt,
    output logic                          tx_enable,
    output logic                          tx_load,
    output logic [UART_WORD_W-1:0]        tx_data,
    output logic                          busy,
    output logic [$clog2(NREQ)-1:0]       cur_id,
    output logic                          frame_done,
    output logic [15:0]                   frames_sent
);

    localparam int IW         = $clog2(NREQ);
    localparam int CW         = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);
    localparam int FRAME_LAST = FRAME_CYCLES - 1;
    localparam int GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    arb_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NREQ-1:0]        gnt_q, gnt_d;
    logic                   tx_enable_q, tx_enable_d;
    logic                   tx_load_q, tx_load_d;
    logic [UART_WORD_W-1:0] tx_data_q, tx_data_d;
    logic                   busy_q, busy_d;
    logic [IW-1:0]          cur_id_q, cur_id_d;
    logic                   frame_done_q, frame_done_d;
    logic [15:0]            frames_sent_q, frames_sent_d;

    logic                   pick_valid;
    logic [IW-1:0]          pick_idx;
    logic                   grant;
    logic                   send_last;
    logic                   gap_last;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req   (req),
        .last  (cur_id_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign grant     = (state_q == IDLE) && arb_en && pick_valid;
    assign send_last = (cnt_q == CW'(FRAME_LAST));
    assign gap_last  = (cnt_q == CW'(GAP_LAST));

    // State register and output flops
    always_ff @(posedge txclk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            gnt_q         <= '0;
            tx_enable_q   <= 1'b0;
            tx_load_q     <= 1'b0;
            tx_data_q     <= '0;
            busy_q        <= 1'b0;
            cur_id_q      <= IW'(NREQ - 1);
            frame_done_q  <= 1'b0;
            frames_sent_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gnt_q         <= gnt_d;
            tx_enable_q   <= tx_enable_d;
            tx_load_q     <= tx_load_d;
            tx_data_q     <= tx_data_d;
            busy_q        <= busy_d;
            cur_id_q      <= cur_id_d;
            frame_done_q  <= frame_done_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    // Next state and frame/gap counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = SEND;
                    cnt_d   = '0;
                end
            end
            SEND: begin
                if (send_last) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (gap_last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs; tx_data and cur_id hold between grants
    always_comb begin
        gnt_d         = '0;
        tx_load_d     = 1'b0;
        frame_done_d  = 1'b0;
        tx_enable_d   = tx_enable_q;
        tx_data_d     = tx_data_q;
        busy_d        = busy_q;
        cur_id_d      = cur_id_q;
        frames_sent_d = frames_sent_q;
        case (state_q)
            IDLE: begin
                tx_enable_d = 1'b0;
                busy_d      = 1'b0;
                if (grant) begin
                    gnt_d[pick_idx] = 1'b1;
                    cur_id_d        = pick_idx;
                    tx_data_d       = req_data[int'(pick_idx)*UART_WORD_W +: UART_WORD_W];
                    tx_enable_d     = 1'b1;
                    tx_load_d       = 1'b1;
                    busy_d          = 1'b1;
                end
            end
            SEND: begin
                if (send_last) begin
                    tx_enable_d   = 1'b0;
                    frame_done_d  = 1'b1;
                    frames_sent_d = frames_sent_q + 16'd1;
                    busy_d        = (GAP_CYCLES > 0);
                end
            end
            GAP: begin
                tx_enable_d = 1'b0;
                busy_d      = !gap_last;
            end
            default: begin
                tx_enable_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    assign gnt         = gnt_q;
    assign tx_enable   = tx_enable_q;
    assign tx_load     = tx_load_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign cur_id      = cur_id_q;
    assign frame_done  = frame_done_q;
    assign frames_sent = frames_sent_q;

endmodule
